// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer with HI/LO commit and D-stage stall request.
// Optional MDU_MADD_EN enables the madd/maddu/msub/msubu accumulate ops (codes 7-10).
module mdu_ctrl #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use_d,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall_req
);

  typedef enum logic {IDLE, RUN} state_t;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } op_t;

  state_t      state;
  logic [31:0] cnt;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;

  logic [63:0] a_sx, b_sx, prod_s, prod_u;
  logic [31:0] mag_a, mag_b, uq, ur, sq, sr, dq, dr;
  logic        div_zero;
  logic [63:0] res;
  logic        op_ok;
  logic        is_div;

  assign a_sx   = {{32{rs_val[31]}}, rs_val};
  assign b_sx   = {{32{rt_val[31]}}, rt_val};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

  // Signed divide via magnitudes: no signed-overflow corner, and 0x80000000/-1 falls out naturally.
  assign mag_a    = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
  assign mag_b    = rt_val[31] ? (~rt_val + 32'd1) : rt_val;
  assign div_zero = (rt_val == '0);
  assign uq       = div_zero ? '0 : mag_a / mag_b;
  assign ur       = div_zero ? '0 : mag_a % mag_b;
  assign sq       = (rs_val[31] ^ rt_val[31]) ? (~uq + 32'd1) : uq;
  assign sr       = rs_val[31] ? (~ur + 32'd1) : ur;
  assign dq       = div_zero ? '0 : rs_val / rt_val;
  assign dr       = div_zero ? '0 : rs_val % rt_val;

  always_comb begin
    res    = {hi, lo};
    op_ok  = 1'b0;
    is_div = 1'b0;
    case (md_op)
      OP_MULT:  begin op_ok = 1'b1; res = prod_s; end
      OP_MULTU: begin op_ok = 1'b1; res = prod_u; end
      OP_DIV: begin
        op_ok  = 1'b1;
        is_div = 1'b1;
        if (!div_zero) res = {sr, sq};
      end
      OP_DIVU: begin
        op_ok  = 1'b1;
        is_div = 1'b1;
        if (!div_zero) res = {dr, dq};
      end
`ifdef MDU_MADD_EN
      OP_MADD:  begin op_ok = 1'b1; res = {hi, lo} + prod_s; end
      OP_MADDU: begin op_ok = 1'b1; res = {hi, lo} + prod_u; end
      OP_MSUB:  begin op_ok = 1'b1; res = {hi, lo} - prod_s; end
      OP_MSUBU: begin op_ok = 1'b1; res = {hi, lo} - prod_u; end
`endif
      default: ;
    endcase
  end

  assign stall_req = md_use_d & (busy | start);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && op_ok) begin
            pend_hi <= res[63:32];
            pend_lo <= res[31:0];
            cnt     <= is_div ? 32'(DIV_CYCLES) : 32'(MUL_CYCLES);
            busy    <= 1'b1;
            state   <= RUN;
          end else if (!start && md_op == OP_MTHI) begin
            hi <= rs_val;
          end else if (!start && md_op == OP_MTLO) begin
            lo <= rs_val;
          end
        end
        RUN: begin
          if (cnt == 32'd1) begin
            hi    <= pend_hi;
            lo    <= pend_lo;
            busy  <= 1'b0;
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
